// File: rtl/rhythm_pkg.sv
// Shared types and constants for the rhythm-game beat tracker.
// Holds HID keycodes, the lane index type and the lane state encoding.
package rhythm_pkg;

    localparam logic [7:0] KEY_SPACE = 8'd44;
    localparam logic [7:0] KEY_Q     = 8'd20;

    // Lane keys d, f, j, k; KEY_LANE[0] is lane 0.
    localparam logic [0:3][7:0] KEY_LANE = {8'd7, 8'd9, 8'd13, 8'd14};

    typedef logic [1:0] circletype_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        APPROACH = 2'd1,
        HIT      = 2'd2,
        MISS     = 2'd3
    } lane_state_t;

endpackage

// File: rtl/circle_lane.sv
// One approach-circle lane: state, shrinking radius and flash timer.
// Ports: Clk, Reset, i_clear (sync clear), i_spawn, i_tick, i_press;
//        o_state, o_radius, o_hit_evt / o_miss_evt (resolve this cycle).
module circle_lane
    import rhythm_pkg::*;
#(
    parameter int unsigned START_RADIUS = 64,
    parameter int unsigned RADIUS_STEP  = 1,
    parameter int unsigned HIT_WINDOW   = 8,
    parameter int unsigned FLASH_FRAMES = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        i_clear,
    input  logic        i_spawn,
    input  logic        i_tick,
    input  logic        i_press,
    output lane_state_t o_state,
    output logic [7:0]  o_radius,
    output logic        o_hit_evt,
    output logic        o_miss_evt
);

    lane_state_t r_state;
    logic [7:0]  r_radius;
    logic [7:0]  r_flash;

    logic w_approach;
    logic w_in_window;

    assign w_approach  = (r_state == APPROACH) && !i_clear;
    assign w_in_window = (r_radius <= 8'(HIT_WINDOW));

    // A press is judged before the tick, so it overrides a tick-miss.
    assign o_hit_evt  = w_approach && i_press && w_in_window;
    assign o_miss_evt = w_approach &&
                        (i_press ? !w_in_window
                                 : (i_tick && (r_radius == 8'd0)));

    assign o_state  = r_state;
    assign o_radius = r_radius;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_radius <= '0;
            r_flash  <= '0;
        end else if (i_clear) begin
            r_state  <= IDLE;
            r_radius <= '0;
            r_flash  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_spawn) begin
                        r_state  <= APPROACH;
                        r_radius <= 8'(START_RADIUS);
                    end
                end
                APPROACH: begin
                    if (i_press) begin
                        r_state <= w_in_window ? HIT : MISS;
                        r_flash <= 8'(FLASH_FRAMES);
                    end else if (i_tick) begin
                        if (r_radius == 8'd0) begin
                            r_state <= MISS;
                            r_flash <= 8'(FLASH_FRAMES);
                        end else if (r_radius > 8'(RADIUS_STEP)) begin
                            r_radius <= r_radius - 8'(RADIUS_STEP);
                        end else begin
                            r_radius <= '0;
                        end
                    end
                end
                HIT, MISS: begin
                    if (i_tick) begin
                        if (r_flash == 8'd0) begin
                            r_state  <= IDLE;
                            r_radius <= '0;
                        end else begin
                            r_flash <= r_flash - 8'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/beat_circle_tracker.sv
// Four-lane approach-circle tracker: key edges, health, resolve pulse.
// Ports: Clk, Reset, frame_tick, main, spawn, circletype, keycode;
//        out_of_bounds, health, circle_active/radius, hit/miss_flash.
module beat_circle_tracker
    import rhythm_pkg::*;
#(
    parameter int unsigned START_RADIUS = 64,
    parameter int unsigned RADIUS_STEP  = 1,
    parameter int unsigned HIT_WINDOW   = 8,
    parameter int unsigned FLASH_FRAMES = 15,
    parameter int unsigned INIT_HEALTH  = 4,
    parameter int unsigned MAX_HEALTH   = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        main,
    input  logic        spawn,
    input  circletype_t circletype,
    input  logic [7:0]  keycode,
    output logic        out_of_bounds,
    output logic [3:0]  health,
    output logic [3:0]  circle_active,
    output logic [31:0] circle_radius,
    output logic [3:0]  hit_flash,
    output logic [3:0]  miss_flash
);

    logic [7:0] r_prev_key;
    logic [3:0] r_health;
    logic       r_oob;

    logic [3:0]        w_press;
    logic [3:0]        w_hit;
    logic [3:0]        w_miss;
    lane_state_t       w_state [4];
    logic [2:0]        w_nhit;
    logic [2:0]        w_nmiss;
    logic signed [3:0] w_delta;
    logic signed [5:0] w_sum;
    logic [3:0]        w_next_health;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        // Only the cycle the key appears counts as a press.
        assign w_press[g] = (keycode == KEY_LANE[g]) &&
                            (r_prev_key != KEY_LANE[g]);

        circle_lane #(
            .START_RADIUS (START_RADIUS),
            .RADIUS_STEP  (RADIUS_STEP),
            .HIT_WINDOW   (HIT_WINDOW),
            .FLASH_FRAMES (FLASH_FRAMES)
        ) u_lane (
            .Clk        (Clk),
            .Reset      (Reset),
            .i_clear    (main),
            .i_spawn    (spawn && (circletype == circletype_t'(g))),
            .i_tick     (frame_tick),
            .i_press    (w_press[g]),
            .o_state    (w_state[g]),
            .o_radius   (circle_radius[8*g +: 8]),
            .o_hit_evt  (w_hit[g]),
            .o_miss_evt (w_miss[g])
        );

        assign circle_active[g] = (w_state[g] == APPROACH);
        assign hit_flash[g]     = (w_state[g] == HIT);
        assign miss_flash[g]    = (w_state[g] == MISS);
    end

    always_comb begin
        w_nhit  = '0;
        w_nmiss = '0;
        for (int i = 0; i < 4; i++) begin
            w_nhit  = w_nhit  + {2'b00, w_hit[i]};
            w_nmiss = w_nmiss + {2'b00, w_miss[i]};
        end
    end

    // Sum in 6-bit signed so both under- and overflow are visible.
    always_comb begin
        w_delta = $signed({1'b0, w_nhit}) - $signed({1'b0, w_nmiss});
        w_sum   = $signed({2'b00, r_health}) +
                  $signed({{2{w_delta[3]}}, w_delta});
        if (w_sum[5]) begin
            w_next_health = '0;
        end else if (w_sum > $signed(6'(MAX_HEALTH))) begin
            w_next_health = 4'(MAX_HEALTH);
        end else begin
            w_next_health = w_sum[3:0];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_prev_key <= '0;
            r_health   <= 4'(INIT_HEALTH);
            r_oob      <= 1'b0;
        end else begin
            r_prev_key <= keycode;
            if (main) begin
                r_health <= 4'(INIT_HEALTH);
                r_oob    <= 1'b0;
            end else begin
                r_health <= w_next_health;
                r_oob    <= |(w_hit | w_miss);
            end
        end
    end

    assign out_of_bounds = r_oob;
    assign health        = r_health;

endmodule
